// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared widths, port ids and FSM encoding for the data-memory arbiter
package dmem_arbiter_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RWAIT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_starve_pick.sv
// rtl/arb_starve_pick.sv - fixed-priority winner pick with a saturating port-1 starvation guard
module arb_starve_pick #(
    parameter int STARVE_MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_arb_en,
    input  logic i_r0_req,
    input  logic i_r1_req,
    output logic o_win_valid,
    output logic o_win_port
);
    import dmem_arbiter_pkg::*;

    logic [3:0] r_starve_cnt;
    logic       w_starved;

    assign w_starved = (r_starve_cnt == 4'(STARVE_MAX));

    always_comb begin
        o_win_valid = i_r0_req | i_r1_req;
        if (i_r0_req && i_r1_req) begin
            o_win_port = w_starved ? PORT_AUX : PORT_CPU;
        end else begin
            o_win_port = i_r1_req ? PORT_AUX : PORT_CPU;
        end
    end

    // Counts only arbitrations port 1 actually lost; any idle cycle without r1_req forgives the debt.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
        end else if (i_arb_en) begin
            if (!i_r1_req || o_win_port == PORT_AUX) begin
                r_starve_cnt <= '0;
            end else if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of the single-port data memory
module dmem_arbiter #(
    parameter int ADDR_W     = dmem_arbiter_pkg::ADDR_W,
    parameter int DATA_W     = dmem_arbiter_pkg::DATA_W,
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    import dmem_arbiter_pkg::*;

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [1:0]        r_lat_cnt;
    logic              r_port;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_win_valid;
    logic              w_win_port;
    logic              w_idle;
    logic              w_rd_last;

    logic              w_gnt0_nxt;
    logic              w_gnt1_nxt;
    logic              w_rv0_nxt;
    logic              w_rv1_nxt;
    logic              w_mrd_nxt;
    logic              w_mwr_nxt;
    logic              w_busy_nxt;
    logic [ADDR_W-1:0] w_maddr_nxt;
    logic [DATA_W-1:0] w_mwdata_nxt;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_rd_last = (r_lat_cnt == 2'(READ_LAT - 1));

    arb_starve_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_arb_en    (w_idle),
        .i_r0_req    (r0_req),
        .i_r1_req    (r1_req),
        .o_win_valid (w_win_valid),
        .o_win_port  (w_win_port)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_win_valid) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = r_we ? ST_IDLE : ST_RWAIT;
            ST_RWAIT:  if (w_rd_last) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the current state and registered, so they trail the state by a cycle.
    always_comb begin
        w_gnt0_nxt   = 1'b0;
        w_gnt1_nxt   = 1'b0;
        w_rv0_nxt    = 1'b0;
        w_rv1_nxt    = 1'b0;
        w_mrd_nxt    = 1'b0;
        w_mwr_nxt    = 1'b0;
        w_busy_nxt   = 1'b0;
        w_maddr_nxt  = '0;
        w_mwdata_nxt = '0;
        case (r_state)
            ST_ACCESS: begin
                w_busy_nxt  = 1'b1;
                w_gnt0_nxt  = (r_port == PORT_CPU);
                w_gnt1_nxt  = (r_port == PORT_AUX);
                w_maddr_nxt = r_addr;
                if (r_we) begin
                    w_mwr_nxt    = 1'b1;
                    w_mwdata_nxt = r_wdata;
                end else begin
                    w_mrd_nxt = 1'b1;
                end
            end
            ST_RWAIT: begin
                w_busy_nxt  = 1'b1;
                w_mrd_nxt   = 1'b1;
                w_maddr_nxt = r_addr;
                w_rv0_nxt   = w_rd_last && (r_port == PORT_CPU);
                w_rv1_nxt   = w_rd_last && (r_port == PORT_AUX);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_port    <= PORT_CPU;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_lat_cnt <= '0;
        end else begin
            if (w_idle && w_win_valid) begin
                r_port  <= w_win_port;
                r_we    <= (w_win_port == PORT_AUX) ? r1_we    : r0_we;
                r_addr  <= (w_win_port == PORT_AUX) ? r1_addr  : r0_addr;
                r_wdata <= (w_win_port == PORT_AUX) ? r1_wdata : r0_wdata;
            end
            r_lat_cnt <= (r_state == ST_RWAIT) ? r_lat_cnt + 2'd1 : 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r0_gnt    <= 1'b0;
            r1_gnt    <= 1'b0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            r0_gnt    <= w_gnt0_nxt;
            r1_gnt    <= w_gnt1_nxt;
            r0_rvalid <= w_rv0_nxt;
            r1_rvalid <= w_rv1_nxt;
            mem_read  <= w_mrd_nxt;
            mem_write <= w_mwr_nxt;
            mem_addr  <= w_maddr_nxt;
            mem_wdata <= w_mwdata_nxt;
            busy      <= w_busy_nxt;
            if (r_state == ST_RWAIT && w_rd_last) begin
                if (r_port == PORT_CPU) begin
                    r0_rdata <= mem_rdata;
                end else begin
                    r1_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int LAT  = 1;
    localparam int SMAX = 4;
    localparam int MAXC = 4096;

    typedef struct packed {
        logic       g0, g1, rv0, rv1, mr, mw, busy;
        logic [5:0] addr;
        logic [7:0] wd;
        logic [7:0] rd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       r0_req, r0_we, r1_req, r1_we;
    logic [5:0] r0_addr, r1_addr;
    logic [7:0] r0_wdata, r1_wdata;
    logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [7:0] r0_rdata, r1_rdata;
    logic       mem_read, mem_write, busy;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    logic       rst3;
    logic       q0_req, q0_we, q1_req, q1_we;
    logic [5:0] q0_addr, q1_addr;
    logic [7:0] q0_wdata, q1_wdata;
    logic       q0_gnt, q0_rvalid, q1_gnt, q1_rvalid;
    logic [7:0] q0_rdata, q1_rdata;
    logic       q_mem_read, q_mem_write, q_busy;
    logic [5:0] q_mem_addr;
    logic [7:0] q_mem_wdata, q_mem_rdata;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         free_at = 0;
    int         starve = 0;
    int         pend0 = 0;
    int         pend1 = 0;
    bit         rnd_on = 1'b0;
    logic       m_p;
    logic [7:0] m_rd0 = 8'h00;
    logic [7:0] m_rd1 = 8'h00;
    logic [7:0] tb_mem [64];
    logic [7:0] mdl_mem [64];
    exp_t       exp_q [MAXC];
    exp_t       e;
    logic [36:0] av, ev;

    dmem_arbiter #(.READ_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    dmem_arbiter #(.READ_LAT(3), .STARVE_MAX(SMAX)) u_dut3 (
        .clk(clk), .reset(rst3),
        .r0_req(q0_req), .r0_we(q0_we), .r0_addr(q0_addr), .r0_wdata(q0_wdata),
        .r0_gnt(q0_gnt), .r0_rvalid(q0_rvalid), .r0_rdata(q0_rdata),
        .r1_req(q1_req), .r1_we(q1_we), .r1_addr(q1_addr), .r1_wdata(q1_wdata),
        .r1_gnt(q1_gnt), .r1_rvalid(q1_rvalid), .r1_rdata(q1_rdata),
        .mem_read(q_mem_read), .mem_write(q_mem_write), .mem_addr(q_mem_addr),
        .mem_wdata(q_mem_wdata), .mem_rdata(q_mem_rdata), .busy(q_busy)
    );

    // Memories return data while mem_read is held on the addressed word.
    assign mem_rdata   = mem_read ? tb_mem[mem_addr] : 8'h00;
    assign q_mem_rdata = q_mem_read ? 8'h5A : 8'h00;

    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Transaction-level expectation: a request accepted at edge n owns the memory
    // for cycles n+1 .. n+1 (write) or n+1 .. n+1+LAT (read).
    task automatic schedule(input int n, input logic p, input logic we,
                            input logic [5:0] a, input logic [7:0] d);
        int last;
        last = we ? n + 1 : n + 1 + LAT;
        for (int k = n + 1; k <= last; k++) begin
            exp_q[k].busy = 1'b1;
            exp_q[k].addr = a;
            if (we) begin
                exp_q[k].mw = 1'b1;
                exp_q[k].wd = d;
            end else begin
                exp_q[k].mr = 1'b1;
            end
        end
        if (p) exp_q[n + 1].g1 = 1'b1;
        else   exp_q[n + 1].g0 = 1'b1;
        if (we) begin
            mdl_mem[a] = d;
        end else begin
            if (p) exp_q[last].rv1 = 1'b1;
            else   exp_q[last].rv0 = 1'b1;
            exp_q[last].rd = mdl_mem[a];
        end
        free_at = last + 1;
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            starve  = 0;
            free_at = 0;
        end else if (cyc >= free_at && cyc < MAXC - 8) begin
            if (r0_req || r1_req) begin
                m_p = (r0_req && r1_req) ? (starve == SMAX) : r1_req;
                if (!r1_req || m_p) starve = 0;
                else if (starve < SMAX) starve = starve + 1;
                if (m_p) schedule(cyc, 1'b1, r1_we, r1_addr, r1_wdata);
                else     schedule(cyc, 1'b0, r0_we, r0_addr, r0_wdata);
            end else begin
                starve = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            e = exp_q[cyc];
            if (e.rv0) m_rd0 = e.rd;
            if (e.rv1) m_rd1 = e.rd;
            av = {r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
                  mem_read, mem_write, mem_addr, mem_wdata, busy};
            ev = {e.g0, e.rv0, m_rd0, e.g1, e.rv1, m_rd1,
                  e.mr, e.mw, e.addr, e.wd, e.busy};
            checks++;
            if (av !== ev) begin
                errors++;
                $display("FAIL model cycle %0d: got %h required %h", cyc, av, ev);
            end
        end
        if (rnd_on) begin
            checks++;
            if (mem_read && mem_write) begin
                errors++;
                $display("FAIL strobe_excl cycle %0d: got rd=1 wr=1 required not both", cyc);
            end
            if (r0_gnt && mem_read) pend0++;
            if (r1_gnt && mem_read) pend1++;
            if (r0_rvalid) pend0--;
            if (r1_rvalid) pend1--;
        end
    end

    initial begin
        int gseq[$];
        int n;
        int cnt;
        int exp_seq[6];
        exp_seq = '{0, 0, 0, 0, 1, 0};
        for (int i = 0; i < MAXC; i++) exp_q[i] = '0;
        for (int i = 0; i < 64; i++) begin
            tb_mem[i]  = 8'(i * 7 + 3);
            mdl_mem[i] = 8'(i * 7 + 3);
        end
        tb_mem[16]  = 8'h3C;
        mdl_mem[16] = 8'h3C;
        reset = 1'b0; rst3 = 1'b0;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
        q0_req = 0; q0_we = 0; q0_addr = 0; q0_wdata = 0;
        q1_req = 0; q1_we = 0; q1_addr = 0; q1_wdata = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_q_rdata", q0_rdata, 0);
        reset = 1'b1; rst3 = 1'b1;
        @(negedge clk);

        // single write, port 0
        r0_req = 1; r0_we = 1; r0_addr = 6'h05; r0_wdata = 8'hA5;
        @(negedge clk);
        chk("t1_gnt_c0", r0_gnt, 0);
        @(negedge clk);
        chk("t1_gnt", r0_gnt, 1);
        chk("t1_mem_write", mem_write, 1);
        chk("t1_mem_addr", mem_addr, 6'h05);
        chk("t1_mem_wdata", mem_wdata, 8'hA5);
        r0_req = 0;
        @(negedge clk);
        chk("t1_busy_c2", busy, 0);

        // single read, port 1
        r1_req = 1; r1_we = 0; r1_addr = 6'h10;
        @(negedge clk);
        @(negedge clk);
        chk("t2_gnt", r1_gnt, 1);
        chk("t2_mem_read_c1", mem_read, 1);
        r1_req = 0;
        @(negedge clk);
        chk("t2_mem_read_c2", mem_read, 1);
        chk("t2_rvalid", r1_rvalid, 1);
        chk("t2_rdata", r1_rdata, 8'h3C);
        chk("t2_r0_rvalid", r0_rvalid, 0);
        @(negedge clk);
        chk("t2_rvalid_c3", r1_rvalid, 0);
        chk("t2_rdata_hold", r1_rdata, 8'h3C);

        // contention: both ports write continuously
        r0_req = 1; r0_we = 1; r0_addr = 6'h01; r0_wdata = 8'h11;
        r1_req = 1; r1_we = 1; r1_addr = 6'h02; r1_wdata = 8'h22;
        n = 0;
        while (gseq.size() < 6 && n < 60) begin
            @(negedge clk);
            n++;
            if (r0_gnt) gseq.push_back(0);
            if (r1_gnt) gseq.push_back(1);
        end
        r0_req = 0; r1_req = 0;
        chk("t3_grant_count", gseq.size(), 6);
        for (int i = 0; i < 6 && i < gseq.size(); i++) chk($sformatf("t3_grant%0d", i), gseq[i], exp_seq[i]);
        repeat (2) @(negedge clk);

        // withdrawal while busy with a port 0 read
        r0_req = 1; r0_we = 0; r0_addr = 6'h10;
        @(negedge clk);
        @(negedge clk);
        chk("t4_gnt", r0_gnt, 1);
        r0_req = 0;
        r1_req = 1; r1_we = 1; r1_addr = 6'h3F; r1_wdata = 8'hEE;
        @(negedge clk);
        chk("t4_rdata", r0_rdata, 8'h3C);
        r1_req = 0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (r1_gnt || mem_write || mem_read) cnt++;
        end
        chk("t4_no_access", cnt, 0);

        // random traffic
        rnd_on = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (r0_req && r0_gnt) r0_req = 0;
            else if (r0_req && $urandom_range(0, 15) == 0) r0_req = 0;
            else if (!r0_req && $urandom_range(0, 2) == 0) begin
                r0_req = 1; r0_we = 1'($urandom); r0_addr = 6'($urandom); r0_wdata = 8'($urandom);
            end
            if (r1_req && r1_gnt) r1_req = 0;
            else if (r1_req && $urandom_range(0, 15) == 0) r1_req = 0;
            else if (!r1_req && $urandom_range(0, 2) == 0) begin
                r1_req = 1; r1_we = 1'($urandom); r1_addr = 6'($urandom); r1_wdata = 8'($urandom);
            end
        end
        r0_req = 0; r1_req = 0;
        repeat (8) @(negedge clk);
        rnd_on = 1'b0;
        chk("rnd_pend0", pend0, 0);
        chk("rnd_pend1", pend1, 0);

        // reset in the second RWAIT cycle of a READ_LAT=3 read
        q0_req = 1; q0_we = 0; q0_addr = 6'h21;
        @(negedge clk);
        @(negedge clk);
        chk("t5_gnt", q0_gnt, 1);
        q0_req = 0;
        @(negedge clk);
        chk("t5_mem_read_pre", q_mem_read, 1);
        chk("t5_busy_pre", q_busy, 1);
        rst3 = 1'b0;
        #1;
        chk("t5_mem_read_rst", q_mem_read, 0);
        chk("t5_busy_rst", q_busy, 0);
        chk("t5_gnt_rst", q0_gnt, 0);
        chk("t5_rvalid_rst", q0_rvalid, 0);
        @(negedge clk);
        rst3 = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (q0_rvalid || q1_rvalid) cnt++;
        end
        chk("t5_no_rvalid", cnt, 0);
        q0_req = 1; q0_we = 0; q0_addr = 6'h22;
        @(negedge clk);
        chk("t5_new_gnt_c0", q0_gnt, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("t5_new_gnt", q0_gnt, 1);
                q0_req = 0;
            end
            chk($sformatf("t5_new_rvalid_c%0d", k), q0_rvalid, (k == 4) ? 1 : 0);
            if (k == 4) chk("t5_new_rdata", q0_rdata, 8'h5A);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
